axis_packet_arbiter: RTL



---
 rtl/axis_packet_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
// Merges NUM_STREAMS AXI-stream inputs onto one registered output.
// Arbitration is round-robin at packet granularity. Once an input is granted,
// it owns the output until its tlast beat is accepted.
// Output tid carries the index of the source input of each beat.
//
// Handshake rule on every port: a beat transfers on a rising clk edge where
// tvalid && tready are both high. A source holds tdata/tlast stable while
// tvalid is high and tready is low. axis_i_tready depends on axis_o_tready
// combinationally, but never on any tvalid.
module axis_packet_arbiter #(
   parameter int AXIS_BYTES  = 1,
   parameter int NUM_STREAMS = 2,
   parameter int ID_BITS     = $clog2(NUM_STREAMS)
) (
   input  logic                                clk,
   input  logic                                areset,
   output logic [NUM_STREAMS-1:0]              axis_i_tready,
   input  logic [NUM_STREAMS-1:0]              axis_i_tvalid,
   input  logic [NUM_STREAMS-1:0]              axis_i_tlast,
   input  logic [NUM_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
   input  logic                                axis_o_tready,
   output logic                                axis_o_tvalid,
   output logic                                axis_o_tlast,
   output logic [AXIS_BYTES*8-1:0]             axis_o_tdata,
   output logic [ID_BITS-1:0]                  axis_o_tid
);

   localparam int W = AXIS_BYTES * 8;

   // Two-state packet FSM: IDLE arbitrates, LOCKED forwards one packet.
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state_q, state_d;
   logic [ID_BITS-1:0] grant_q, grant_d;
   logic [ID_BITS-1:0] last_grant_q, last_grant_d;

   logic               o_valid_q, o_valid_d;
   logic               o_last_q, o_last_d;
   logic [W-1:0]       o_data_q, o_data_d;
   logic [ID_BITS-1:0] o_tid_q, o_tid_d;

   // Per-stream view of the flat data bus.
   logic [W-1:0] in_data [NUM_STREAMS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_STREAMS; gi++) begin : g_unpack
         assign in_data[gi] = axis_i_tdata[(gi+1)*W-1 -: W];
      end
   endgenerate

   // The output register can take a new beat when empty or draining this cycle.
   logic out_free;
   assign out_free = !o_valid_q || axis_o_tready;

   // Signals of the granted input only. Other inputs are ignored.
   logic         sel_valid;
   logic         sel_last;
   logic [W-1:0] sel_data;
   logic         beat_acc;

   assign sel_valid = axis_i_tvalid[grant_q];
   assign sel_last  = axis_i_tlast[grant_q];
   assign sel_data  = in_data[grant_q];

   // Only the granted input is ever ready, and only while LOCKED with room downstream.
   always_comb begin
      axis_i_tready = '0;
      if (state_q == ST_LOCKED) begin
         axis_i_tready[grant_q] = out_free;
      end
   end

   assign beat_acc = (state_q == ST_LOCKED) && sel_valid && out_free;

   // Round-robin search: first valid index starting just after the last grant.
   logic               arb_found;
   logic [ID_BITS-1:0] arb_pick;
   logic [ID_BITS-1:0] arb_idx;
   int                 arb_sum;

   always_comb begin
      arb_found = 1'b0;
      arb_pick  = '0;
      arb_idx   = '0;
      arb_sum   = 0;
      for (int k = 1; k <= NUM_STREAMS; k++) begin
         arb_sum = (int'(last_grant_q) + k) % NUM_STREAMS;
         arb_idx = ID_BITS'(arb_sum);
         if (!arb_found && axis_i_tvalid[arb_idx]) begin
            arb_found = 1'b1;
            arb_pick  = arb_idx;
         end
      end
   end

   // Next-state logic for the FSM and grant bookkeeping.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               grant_d = arb_pick;
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            // The tlast cycle itself never grants; the next IDLE cycle does.
            if (beat_acc && sel_last) begin
               last_grant_d = grant_q;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output register: a new beat has priority over a drain, otherwise hold.
   always_comb begin
      o_valid_d = o_valid_q;
      o_last_d  = o_last_q;
      o_data_d  = o_data_q;
      o_tid_d   = o_tid_q;
      if (beat_acc) begin
         o_valid_d = 1'b1;
         o_last_d  = sel_last;
         o_data_d  = sel_data;
         o_tid_d   = grant_q;
      end else if (o_valid_q && axis_o_tready) begin
         o_valid_d = 1'b0;
      end
   end

   // State registers. An asynchronous reset abandons any partial packet.
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_BITS'(NUM_STREAMS - 1);
         o_valid_q    <= 1'b0;
         o_last_q     <= 1'b0;
         o_data_q     <= '0;
         o_tid_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         o_valid_q    <= o_valid_d;
         o_last_q     <= o_last_d;
         o_data_q     <= o_data_d;
         o_tid_q      <= o_tid_d;
      end
   end

   assign axis_o_tvalid = o_valid_q;
   assign axis_o_tlast  = o_last_q;
   assign axis_o_tdata  = o_data_q;
   assign axis_o_tid    = o_tid_q;

endmodule
